// File: rtl/dmem_access_ctrl_rv_pkg.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_rv_pkg
//
// Purpose: shared constants and types for the RV data-memory access sequencer.
// It holds the memory access width codes, the exception codes reported on
// completion, the sequencer state encoding, and a helper that returns the
// unshifted byte-lane mask for an access width.
//
// Ports: none (package).
// Optional feature macro used by the importing files: DMEM_MISALIGN_SPLIT_EN.
// ---------------------------------------------------------------------------
package dmem_access_ctrl_rv_pkg;

    localparam logic [1:0] MEM_ACCESS_BYTE      = 2'b00;
    localparam logic [1:0] MEM_ACCESS_HALF_WORD = 2'b01;
    localparam logic [1:0] MEM_ACCESS_WORD      = 2'b10;

    localparam logic [3:0] EXCEPTION_SUCCESS          = 4'd0;
    localparam logic [3:0] EXCEPTION_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] EXCEPTION_MISALIGNED_LOAD  = 4'd4;
    localparam logic [3:0] EXCEPTION_BUS_ERROR        = 4'd5;
    localparam logic [3:0] EXCEPTION_MISALIGNED_STORE = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } dmem_state_e;

    // Lane mask for an access that starts at byte 0; an illegal width
    // enables no lanes at all.
    function automatic logic [3:0] base_byte_en(input logic [1:0] access);
        case (access)
            MEM_ACCESS_BYTE:      base_byte_en = 4'b0001;
            MEM_ACCESS_HALF_WORD: base_byte_en = 4'b0011;
            MEM_ACCESS_WORD:      base_byte_en = 4'b1111;
            default:              base_byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align_rv.sv
// ---------------------------------------------------------------------------
// dmem_lane_align_rv
//
// Purpose: purely combinational byte-lane steering for data-memory accesses.
// It treats an access as living in a 64-bit window made of the aligned word
// (low half) and the following word (high half), which covers both single-beat
// accesses and accesses split across two words.
//
// Ports:
//   access      in  2   access width code
//   offset      in  2   byte offset inside the aligned word
//   sign_extend in  1   sign-extend the load result
//   beat_sel    in  1   0 = lanes for the aligned word, 1 = lanes for word+4
//   store_data  in  32  right-aligned store data
//   rword_lo    in  32  read word from the aligned word
//   rword_hi    in  32  read word from word+4 (zero for single-beat accesses)
//   byte_en     out 4   byte enables for the selected beat
//   bus_wdata   out 32  lane-shifted store data for the selected beat
//   load_data   out 32  shifted, masked and extended load result
//
// Optional feature macro in the system: DMEM_MISALIGN_SPLIT_EN (this block is
// identical in both builds; the top decides whether beat_sel/rword_hi are used).
// ---------------------------------------------------------------------------
module dmem_lane_align_rv
    import dmem_access_ctrl_rv_pkg::*;
(
    input  logic [1:0]  access,
    input  logic [1:0]  offset,
    input  logic        sign_extend,
    input  logic        beat_sel,
    input  logic [31:0] store_data,
    input  logic [31:0] rword_lo,
    input  logic [31:0] rword_hi,
    output logic [3:0]  byte_en,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    logic [4:0]  shamt;
    logic [7:0]  ben_wide;
    logic [63:0] wdata_wide;
    logic [31:0] rd_shift;

    // Shifting into the 64-bit window lets bytes that cross the word
    // boundary fall naturally into the high half for the second beat.
    always_comb begin
        shamt      = {offset, 3'b000};
        ben_wide   = {4'b0000, base_byte_en(access)} << offset;
        wdata_wide = {32'h0, store_data} << shamt;
        rd_shift   = 32'({rword_hi, rword_lo} >> shamt);

        byte_en   = beat_sel ? ben_wide[7:4]     : ben_wide[3:0];
        bus_wdata = beat_sel ? wdata_wide[63:32] : wdata_wide[31:0];

        case (access)
            MEM_ACCESS_BYTE:
                load_data = sign_extend ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                        : {24'h0, rd_shift[7:0]};
            MEM_ACCESS_HALF_WORD:
                load_data = sign_extend ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                        : {16'h0, rd_shift[15:0]};
            default:
                load_data = rd_shift;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl_rv.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_rv
//
// Purpose: multi-cycle data-memory access sequencer between decode/execute
// and the data bus. Latches a load/store request, checks legality and
// alignment, runs one (or two, when split) request/ack bus beats with byte
// lane steering, stalls the core meanwhile, and reports the extended load
// data plus an exception code with a one-cycle done pulse.
//
// Parameter: TIMEOUT_CYCLES (>=1) - beat cycles without ack before bus error.
//
// Ports:
//   iwClk, iwRst         clock, synchronous active-high reset
//   iwReq                load/store request level (held while stalled)
//   iwWrite              1 = store, 0 = load
//   iwSignExtend         sign-extend the load result
//   iwAccess             access width code (2'b11 is illegal)
//   iwAddr, iwWData      effective byte address, right-aligned store data
//   owStall              freeze the core while the access is in flight
//   owDone               one-cycle completion pulse
//   owRData, owException load result and exception code, valid with owDone
//   owBusReq, owBusWe    bus request and write strobe
//   owBusAddr            word-aligned bus address
//   owBusByteEn          byte-lane enables
//   owBusWData           lane-shifted store data
//   iwBusAck, iwBusRData bus beat completion and read data
//
// Macro DMEM_MISALIGN_SPLIT_EN: when defined, misaligned words and halves at
// offset 3 run as two bus beats instead of raising a misaligned exception.
// ---------------------------------------------------------------------------
module dmem_access_ctrl_rv
    import dmem_access_ctrl_rv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic        iwReq,
    input  logic        iwWrite,
    input  logic        iwSignExtend,
    input  logic [1:0]  iwAccess,
    input  logic [31:0] iwAddr,
    input  logic [31:0] iwWData,
    output logic        owStall,
    output logic        owDone,
    output logic [31:0] owRData,
    output logic [3:0]  owException,
    output logic        owBusReq,
    output logic        owBusWe,
    output logic [31:0] owBusAddr,
    output logic [3:0]  owBusByteEn,
    output logic [31:0] owBusWData,
    input  logic        iwBusAck,
    input  logic [31:0] iwBusRData
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             write_q, write_d;
    logic             sext_q, sext_d;
    logic [1:0]       access_q, access_d;
    logic [1:0]       offset_q, offset_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [3:0]       bus_ben_q, bus_ben_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic             done_q, done_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [3:0]       exc_q, exc_d;
`ifdef DMEM_MISALIGN_SPLIT_EN
    logic             split_q, split_d;
    logic [31:0]      rword_q, rword_d;
    logic             req_split;
`endif

    logic        in_idle;
    logic        req_illegal;
    logic        req_misaligned;
    logic        finish;
    logic        abort;
    logic [1:0]  al_access;
    logic [1:0]  al_offset;
    logic        al_sext;
    logic        al_beat_sel;
    logic [31:0] al_store;
    logic [31:0] al_rlo;
    logic [31:0] al_rhi;
    logic [3:0]  al_byte_en;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    // In IDLE the lane logic looks at the live request so the first beat can
    // be registered on the request edge; afterwards it uses the latched copy.
    always_comb begin
        in_idle     = (state_q == ST_IDLE);
        al_access   = in_idle ? iwAccess     : access_q;
        al_offset   = in_idle ? iwAddr[1:0]  : offset_q;
        al_sext     = in_idle ? iwSignExtend : sext_q;
        al_store    = in_idle ? iwWData      : wdata_q;
        req_illegal = (iwAccess == 2'b11);
`ifdef DMEM_MISALIGN_SPLIT_EN
        // While not idle the only lane set still to be issued is word+4.
        al_beat_sel    = !in_idle;
        al_rlo         = (state_q == ST_BEAT1) ? rword_q    : iwBusRData;
        al_rhi         = (state_q == ST_BEAT1) ? iwBusRData : 32'h0;
        req_misaligned = 1'b0;
        req_split      = ((iwAccess == MEM_ACCESS_WORD) && (iwAddr[1:0] != 2'b00)) ||
                         ((iwAccess == MEM_ACCESS_HALF_WORD) && (iwAddr[1:0] == 2'b11));
`else
        al_beat_sel    = 1'b0;
        al_rlo         = iwBusRData;
        al_rhi         = 32'h0;
        req_misaligned = ((iwAccess == MEM_ACCESS_HALF_WORD) && iwAddr[0]) ||
                         ((iwAccess == MEM_ACCESS_WORD) && (iwAddr[1:0] != 2'b00));
`endif
    end

    dmem_lane_align_rv u_lane_align (
        .access      (al_access),
        .offset      (al_offset),
        .sign_extend (al_sext),
        .beat_sel    (al_beat_sel),
        .store_data  (al_store),
        .rword_lo    (al_rlo),
        .rword_hi    (al_rhi),
        .byte_en     (al_byte_en),
        .bus_wdata   (al_wdata),
        .load_data   (al_load)
    );

    // Stall asserts combinationally on the request cycle and drops in DONE
    // so the core can retire the instruction on the completion pulse.
    assign owStall = (in_idle && iwReq) || (state_q == ST_BEAT0) || (state_q == ST_BEAT1);

    // Next-state logic. An ack in the last counted cycle is checked before
    // the timeout, so an ack coinciding with expiry completes normally.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        write_d     = write_q;
        sext_d      = sext_q;
        access_d    = access_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_ben_d   = bus_ben_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        exc_d       = exc_q;
        finish      = 1'b0;
        abort       = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
        split_d     = split_q;
        rword_d     = rword_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (iwReq) begin
                    write_d  = iwWrite;
                    sext_d   = iwSignExtend;
                    access_d = iwAccess;
                    offset_d = iwAddr[1:0];
                    wdata_d  = iwWData;
`ifdef DMEM_MISALIGN_SPLIT_EN
                    split_d  = req_split;
`endif
                    if (req_illegal || req_misaligned) begin
                        state_d = ST_DONE;
                        rdata_d = 32'h0;
                        if (req_illegal)
                            exc_d = EXCEPTION_ILLEGAL_INSTR;
                        else
                            exc_d = iwWrite ? EXCEPTION_MISALIGNED_STORE
                                            : EXCEPTION_MISALIGNED_LOAD;
                    end else begin
                        state_d     = ST_BEAT0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = iwWrite;
                        bus_addr_d  = {iwAddr[31:2], 2'b00};
                        bus_ben_d   = al_byte_en;
                        bus_wdata_d = al_wdata;
                        count_d     = '0;
                    end
                end
            end
            ST_BEAT0: begin
                if (iwBusAck) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                    if (split_q) begin
                        rword_d     = iwBusRData;
                        state_d     = ST_BEAT1;
                        bus_addr_d  = bus_addr_q + 32'd4;
                        bus_ben_d   = al_byte_en;
                        bus_wdata_d = al_wdata;
                        count_d     = '0;
                    end else begin
                        finish = 1'b1;
                    end
`else
                    finish = 1'b1;
`endif
                end else if (count_q == CNT_LAST) begin
                    abort = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            ST_BEAT1: begin
                if (iwBusAck)
                    finish = 1'b1;
                else if (count_q == CNT_LAST)
                    abort = 1'b1;
                else
                    count_d = count_q + CNT_W'(1);
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                rdata_d = 32'h0;
                exc_d   = EXCEPTION_SUCCESS;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion and timeout both release the bus and report in DONE.
        if (finish || abort) begin
            state_d     = ST_DONE;
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_addr_d  = 32'h0;
            bus_ben_d   = 4'h0;
            bus_wdata_d = 32'h0;
            rdata_d     = (finish && !write_q) ? al_load : 32'h0;
            exc_d       = finish ? EXCEPTION_SUCCESS : EXCEPTION_BUS_ERROR;
        end

        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs; reset wins over any pending ack.
    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            write_q     <= 1'b0;
            sext_q      <= 1'b0;
            access_q    <= MEM_ACCESS_BYTE;
            offset_q    <= 2'b00;
            wdata_q     <= 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_ben_q   <= 4'h0;
            bus_wdata_q <= 32'h0;
            done_q      <= 1'b0;
            rdata_q     <= 32'h0;
            exc_q       <= EXCEPTION_SUCCESS;
`ifdef DMEM_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            rword_q     <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            write_q     <= write_d;
            sext_q      <= sext_d;
            access_q    <= access_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_ben_q   <= bus_ben_d;
            bus_wdata_q <= bus_wdata_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            exc_q       <= exc_d;
`ifdef DMEM_MISALIGN_SPLIT_EN
            split_q     <= split_d;
            rword_q     <= rword_d;
`endif
        end
    end

    assign owDone      = done_q;
    assign owRData     = rdata_q;
    assign owException = exc_q;
    assign owBusReq    = bus_req_q;
    assign owBusWe     = bus_we_q;
    assign owBusAddr   = bus_addr_q;
    assign owBusByteEn = bus_ben_q;
    assign owBusWData  = bus_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl_rv.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl_rv
//
// Scoreboard bench for dmem_access_ctrl_rv. Each directed request pushes its
// expected completion (cycle, data, exception) and its expected bus beats;
// a bus responder pops beats as owBusReq rises and answers them, and a done
// monitor pops completions whenever owDone pulses.
// Honours DMEM_MISALIGN_SPLIT_EN to select split-access expectations.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl_rv;
    import dmem_access_ctrl_rv_pkg::*;

    localparam int TO = 4;

    logic        iwClk = 1'b0;
    logic        iwRst = 1'b1;
    logic        iwReq = 1'b0;
    logic        iwWrite = 1'b0;
    logic        iwSignExtend = 1'b0;
    logic [1:0]  iwAccess = 2'b00;
    logic [31:0] iwAddr = 32'h0;
    logic [31:0] iwWData = 32'h0;
    logic        iwBusAck = 1'b0;
    logic [31:0] iwBusRData = 32'h0;
    logic        owStall;
    logic        owDone;
    logic [31:0] owRData;
    logic [3:0]  owException;
    logic        owBusReq;
    logic        owBusWe;
    logic [31:0] owBusAddr;
    logic [3:0]  owBusByteEn;
    logic [31:0] owBusWData;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_c;
        bit          ack;
        int          exp_hi;
    } beat_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic [3:0]  exc;
    } done_t;

    beat_t exp_beats[$];
    done_t exp_done[$];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    dmem_access_ctrl_rv #(.TIMEOUT_CYCLES(TO)) dut (
        .iwClk        (iwClk),
        .iwRst        (iwRst),
        .iwReq        (iwReq),
        .iwWrite      (iwWrite),
        .iwSignExtend (iwSignExtend),
        .iwAccess     (iwAccess),
        .iwAddr       (iwAddr),
        .iwWData      (iwWData),
        .owStall      (owStall),
        .owDone       (owDone),
        .owRData      (owRData),
        .owException  (owException),
        .owBusReq     (owBusReq),
        .owBusWe      (owBusWe),
        .owBusAddr    (owBusAddr),
        .owBusByteEn  (owBusByteEn),
        .owBusWData   (owBusWData),
        .iwBusAck     (iwBusAck),
        .iwBusRData   (iwBusRData)
    );

    // Free-running clock; the cycle index is stable between rising edges.
    initial forever #5 iwClk = ~iwClk;

    always @(posedge iwClk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pushBeat(input logic we, input logic [31:0] addr, input logic [3:0] ben,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int wait_c, input bit ack, input int exp_hi);
        beat_t b;
        b.we = we; b.addr = addr; b.ben = ben; b.wdata = wdata;
        b.rdata = rdata; b.wait_c = wait_c; b.ack = ack; b.exp_hi = exp_hi;
        exp_beats.push_back(b);
    endtask

    // Present one request at a falling edge (cycle N), record its expected
    // completion at N+lat, and hold it until the stall drops.
    task automatic applyStimulus(input logic wr, input logic sext, input logic [1:0] acc,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int lat, input logic [31:0] exp_rdata,
                                 input logic [3:0] exp_exc);
        done_t d;
        bit released;
        @(negedge iwClk);
        iwReq = 1'b1; iwWrite = wr; iwSignExtend = sext;
        iwAccess = acc; iwAddr = addr; iwWData = wdata;
        d.cyc = cyc + lat; d.rdata = exp_rdata; d.exc = exp_exc;
        exp_done.push_back(d);
        released = 1'b0;
        for (int i = 0; i < 40 && !released; i++) begin
            @(negedge iwClk);
            if (!owStall) released = 1'b1;
        end
        iwReq = 1'b0;
        if (!released) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL stall_release: stall still 1 after 40 cycles, required 0");
        end
    endtask

    // Bus responder: checks each new beat against the queue, then acks it
    // after its wait count; no-ack beats have their request length checked.
    initial begin
        beat_t cur;
        bit    in_beat;
        int    remain;
        int    hi;
        in_beat = 1'b0; remain = 0; hi = 0;
        cur.ack = 1'b0; cur.exp_hi = -1;
        forever begin
            @(negedge iwClk);
            if (iwBusAck) begin
                iwBusAck = 1'b0;
                in_beat = 1'b0;
            end
            if (owBusReq) begin
                if (!in_beat) begin
                    if (exp_beats.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_bus_req: addr 0x%08h, no beat expected", owBusAddr);
                        cur.ack = 1'b0; cur.exp_hi = -1; cur.wait_c = 0;
                    end else begin
                        cur = exp_beats.pop_front();
                        checkOutput("bus_we", 32'(owBusWe), 32'(cur.we));
                        checkOutput("bus_addr", owBusAddr, cur.addr);
                        checkOutput("bus_byte_en", 32'(owBusByteEn), 32'(cur.ben));
                        checkOutput("bus_wdata", owBusWData, cur.wdata);
                    end
                    in_beat = 1'b1;
                    remain = cur.wait_c;
                    hi = 0;
                end
                hi++;
                if (cur.ack && remain == 0) begin
                    iwBusAck = 1'b1;
                    iwBusRData = cur.rdata;
                end else if (remain > 0) begin
                    remain--;
                end
            end else if (in_beat) begin
                if (cur.exp_hi >= 0) checkOutput("bus_req_cycles", 32'(hi), 32'(cur.exp_hi));
                in_beat = 1'b0;
            end
        end
    end

    // Completion monitor: every done pulse must match the oldest expectation.
    initial begin
        done_t d;
        forever begin
            @(negedge iwClk);
            if (owDone) begin
                if (exp_done.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_done: done at cycle %0d, none expected", cyc);
                end else begin
                    d = exp_done.pop_front();
                    checkOutput("done_cycle", 32'(cyc), 32'(d.cyc));
                    checkOutput("done_rdata", owRData, d.rdata);
                    checkOutput("done_exception", 32'(owException), 32'(d.exc));
                end
            end
        end
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        repeat (3) @(negedge iwClk);
        checkOutput("rst_stall", 32'(owStall), 32'h0);
        checkOutput("rst_done", 32'(owDone), 32'h0);
        checkOutput("rst_rdata", owRData, 32'h0);
        checkOutput("rst_exception", 32'(owException), 32'(EXCEPTION_SUCCESS));
        checkOutput("rst_bus_req", 32'(owBusReq), 32'h0);
        checkOutput("rst_bus_we", 32'(owBusWe), 32'h0);
        checkOutput("rst_bus_addr", owBusAddr, 32'h0);
        checkOutput("rst_bus_byte_en", 32'(owBusByteEn), 32'h0);
        checkOutput("rst_bus_wdata", owBusWData, 32'h0);
        iwRst = 1'b0;

        // LB at 0x1003: top byte 0x80 sign-extends.
        pushBeat(1'b0, 32'h1000, 4'b1000, 32'h0, 32'h8000_0000, 0, 1'b1, -1);
        applyStimulus(1'b0, 1'b1, MEM_ACCESS_BYTE, 32'h1003, 32'h0, 2, 32'hFFFF_FF80, EXCEPTION_SUCCESS);

        // LBU at 0x1001 with one wait cycle: byte 0x80 zero-extends.
        pushBeat(1'b0, 32'h1000, 4'b0010, 32'h0, 32'h1234_8067, 1, 1'b1, -1);
        applyStimulus(1'b0, 1'b0, MEM_ACCESS_BYTE, 32'h1001, 32'h0, 3, 32'h0000_0080, EXCEPTION_SUCCESS);

        // SH at 0x2002 with three wait cycles.
        pushBeat(1'b1, 32'h2000, 4'b1100, 32'hBEEF_0000, 32'h0, 3, 1'b1, -1);
        applyStimulus(1'b1, 1'b0, MEM_ACCESS_HALF_WORD, 32'h2002, 32'h0000_BEEF, 5, 32'h0, EXCEPTION_SUCCESS);

        // LH at 0x2002 sign-extended, LHU at 0x2000 zero-extended.
        pushBeat(1'b0, 32'h2000, 4'b1100, 32'h0, 32'hF00D_1234, 0, 1'b1, -1);
        applyStimulus(1'b0, 1'b1, MEM_ACCESS_HALF_WORD, 32'h2002, 32'h0, 2, 32'hFFFF_F00D, EXCEPTION_SUCCESS);
        pushBeat(1'b0, 32'h2000, 4'b0011, 32'h0, 32'hF00D_8001, 0, 1'b1, -1);
        applyStimulus(1'b0, 1'b0, MEM_ACCESS_HALF_WORD, 32'h2000, 32'h0, 2, 32'h0000_8001, EXCEPTION_SUCCESS);

        // SB at 0x1002 with two wait cycles.
        pushBeat(1'b1, 32'h1000, 4'b0100, 32'h00AB_0000, 32'h0, 2, 1'b1, -1);
        applyStimulus(1'b1, 1'b0, MEM_ACCESS_BYTE, 32'h1002, 32'h0000_00AB, 4, 32'h0, EXCEPTION_SUCCESS);

        // Aligned LW.
        pushBeat(1'b0, 32'h3000, 4'b1111, 32'h0, 32'h0102_0304, 0, 1'b1, -1);
        applyStimulus(1'b0, 1'b0, MEM_ACCESS_WORD, 32'h3000, 32'h0, 2, 32'h0102_0304, EXCEPTION_SUCCESS);

        // Illegal width: no bus activity, done on the next cycle.
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h1000, 32'h0, 1, 32'h0, EXCEPTION_ILLEGAL_INSTR);

`ifdef DMEM_MISALIGN_SPLIT_EN
        // LW at 0x3001 split across 0x3000 / 0x3004.
        pushBeat(1'b0, 32'h3000, 4'b1110, 32'h0, 32'h4433_2211, 0, 1'b1, -1);
        pushBeat(1'b0, 32'h3004, 4'b0001, 32'h0, 32'h8877_6655, 0, 1'b1, -1);
        applyStimulus(1'b0, 1'b0, MEM_ACCESS_WORD, 32'h3001, 32'h0, 3, 32'h5544_3322, EXCEPTION_SUCCESS);

        // SW at 0x3002 split, second beat waits one cycle.
        pushBeat(1'b1, 32'h3000, 4'b1100, 32'h3344_0000, 32'h0, 0, 1'b1, -1);
        pushBeat(1'b1, 32'h3004, 4'b0011, 32'h0000_1122, 32'h0, 1, 1'b1, -1);
        applyStimulus(1'b1, 1'b0, MEM_ACCESS_WORD, 32'h3002, 32'h1122_3344, 4, 32'h0, EXCEPTION_SUCCESS);

        // LH at 0x3003 split and sign-extended: bytes 0xAA then 0xBB.
        pushBeat(1'b0, 32'h3000, 4'b1000, 32'h0, 32'hAA00_0000, 0, 1'b1, -1);
        pushBeat(1'b0, 32'h3004, 4'b0001, 32'h0, 32'h0000_00BB, 0, 1'b1, -1);
        applyStimulus(1'b0, 1'b1, MEM_ACCESS_HALF_WORD, 32'h3003, 32'h0, 3, 32'hFFFF_BBAA, EXCEPTION_SUCCESS);

        // SH at 0x2001 stays a single beat in the middle lanes.
        pushBeat(1'b1, 32'h2000, 4'b0110, 32'h0012_3400, 32'h0, 0, 1'b1, -1);
        applyStimulus(1'b1, 1'b0, MEM_ACCESS_HALF_WORD, 32'h2001, 32'h0000_1234, 2, 32'h0, EXCEPTION_SUCCESS);
`else
        // Misaligned accesses are rejected without touching the bus.
        applyStimulus(1'b0, 1'b0, MEM_ACCESS_WORD, 32'h3001, 32'h0, 1, 32'h0, EXCEPTION_MISALIGNED_LOAD);
        applyStimulus(1'b1, 1'b0, MEM_ACCESS_WORD, 32'h3002, 32'h1122_3344, 1, 32'h0, EXCEPTION_MISALIGNED_STORE);
        applyStimulus(1'b0, 1'b1, MEM_ACCESS_HALF_WORD, 32'h3003, 32'h0, 1, 32'h0, EXCEPTION_MISALIGNED_LOAD);
        applyStimulus(1'b1, 1'b0, MEM_ACCESS_HALF_WORD, 32'h2001, 32'h0000_1234, 1, 32'h0, EXCEPTION_MISALIGNED_STORE);
`endif

        // SW with no ack: request held TO cycles, then bus error.
        pushBeat(1'b1, 32'h6000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, TO);
        applyStimulus(1'b1, 1'b0, MEM_ACCESS_WORD, 32'h6000, 32'hDEAD_BEEF, TO + 1, 32'h0, EXCEPTION_BUS_ERROR);

        // SW acked on the last allowed cycle: ack beats the timeout.
        pushBeat(1'b1, 32'h6000, 4'b1111, 32'h0BAD_F00D, 32'h0, TO - 1, 1'b1, -1);
        applyStimulus(1'b1, 1'b0, MEM_ACCESS_WORD, 32'h6000, 32'h0BAD_F00D, TO + 1, 32'h0, EXCEPTION_SUCCESS);

        // Reset during a BEAT0 wait, coinciding with an ack: no done pulse.
        pushBeat(1'b1, 32'h5000, 4'b1111, 32'h1234_5678, 32'h0, 1, 1'b1, -1);
        @(negedge iwClk);
        iwReq = 1'b1; iwWrite = 1'b1; iwSignExtend = 1'b0;
        iwAccess = MEM_ACCESS_WORD; iwAddr = 32'h5000; iwWData = 32'h1234_5678;
        @(negedge iwClk);
        @(negedge iwClk);
        iwRst = 1'b1;
        iwReq = 1'b0;
        @(negedge iwClk);
        checkOutput("midrst_bus_req", 32'(owBusReq), 32'h0);
        checkOutput("midrst_stall", 32'(owStall), 32'h0);
        checkOutput("midrst_done", 32'(owDone), 32'h0);
        iwRst = 1'b0;
        repeat (2) @(negedge iwClk);

        // A normal LW afterwards.
        pushBeat(1'b0, 32'h4000, 4'b1111, 32'h0, 32'hCAFE_BABE, 0, 1'b1, -1);
        applyStimulus(1'b0, 1'b0, MEM_ACCESS_WORD, 32'h4000, 32'h0, 2, 32'hCAFE_BABE, EXCEPTION_SUCCESS);

        repeat (5) @(negedge iwClk);
        checkOutput("pending_done_left", 32'(exp_done.size()), 32'h0);
        checkOutput("pending_beats_left", 32'(exp_beats.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl_rv.md
# dmem_access_ctrl_rv

Multi-cycle data-memory access sequencer for the RV core. It sits between the instruction decode/execute stage and the data bus. It takes the load/store controls produced by decode (write, sign-extend, access width) and the ALU effective address. It then runs a request/acknowledge bus transaction with byte-lane steering, stalls the core until the access completes, and returns extended load data or an exception code.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255 — cycles `owBusReq` may wait for `iwBusAck` before the access aborts; must be ≥1.

Ports. One clock; reset is synchronous and active-high (`iwClk`, `iwRst`).
- iwClk  in  1  core clock; all state changes on rising edge
- iwRst  in  1  synchronous active-high reset
- iwReq  in  1  decoded instruction is a LOAD/STORE; level, held while `owStall`=1
- iwWrite  in  1  1=store, 0=load
- iwSignExtend  in  1  sign-extend load result
- iwAccess  in  2  `MEM_ACCESS_BYTE` / `HALF_WORD` / `WORD`; 2'b11 is illegal
- iwAddr  in  32  effective byte address (ALU result)
- iwWData  in  32  store data (rs2), value right-aligned
- owStall  out  1  freeze PC/register write
- owDone  out  1  one-cycle completion pulse
- owRData  out  32  extended load data, valid while `owDone`=1
- owException  out  4  `EXCEPTION_*` code, valid while `owDone`=1
- owBusReq  out  1  bus request
- owBusWe  out  1  bus write
- owBusAddr  out  32  word-aligned address, bits[1:0]=0
- owBusByteEn  out  4  byte lane enables
- owBusWData  out  32  lane-shifted store data
- iwBusAck  in  1  bus completes current beat
- iwBusRData  in  32  read word, valid with `iwBusAck`

## Operation
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- Request latching
  - In IDLE with `iwReq`=1, the request is latched and `owStall`=1 combinationally.
  - Alignment check: half needs addr[0]=0; word needs addr[1:0]=0.
  - Illegal access or misaligned address: go to DONE with no bus activity. Exception is `EXCEPTION_ILLEGAL_INSTR` for illegal access, `EXCEPTION_MISALIGNED_LOAD`/`_STORE` for misalignment.
  - Otherwise go to BEAT0.
- BEAT0/BEAT1
  - `owBusReq`=1; address, enables, write data and `owBusWe` held stable until ack.
  - Byte enables: byte → 1<<addr[1:0]; half → 2'b11<<addr[1:0]; word → 4'hF.
  - Store data is shifted left by 8·addr[1:0].
- On ack in BEAT0: load word captured; go to DONE, or BEAT1 if split (see Configuration).
- DONE: `owStall`=0, `owDone`=1, `owRData` and `owException` driven; next state IDLE.
- Load data
  - Read word shifted right by 8·addr[1:0].
  - Result masked to the access width, then zero- or sign-extended per `iwSignExtend`.
  - Store completion returns `owRData`=0.
- Timeout
  - A counter clears on entry to each beat and increments every non-ack beat cycle.
  - When it reaches TIMEOUT_CYCLES: `owBusReq` drops, state goes to DONE with `EXCEPTION_BUS_ERROR`.
- `iwReq` is ignored outside IDLE.

## Timing
- Reset values: state IDLE, counter 0, `owStall`=0, `owDone`=0, `owRData`=0, `owException`=`EXCEPTION_SUCCESS`, `owBusReq`=0, `owBusWe`=0, `owBusAddr`=0, `owBusByteEn`=0, `owBusWData`=0.
- Bus outputs are registered; `owBusReq` rises the cycle after `iwReq` is seen in IDLE.
- Latency
  - Aligned access, zero-wait: request cycle N, ack in N+1, `owDone` at N+2.
  - Each wait cycle adds 1; a split access adds one more beat.
  - Rejected access: `owDone` at N+1.
- An ack that arrives in the same cycle as the timeout expiry wins: the access completes normally.
- `iwRst` mid-access: next edge returns to IDLE with `owBusReq`=0; a pending ack is ignored; no `owDone`.
- `iwBusAck` while `owBusReq`=0 is ignored.

## Configuration
- `DMEM_MISALIGN_SPLIT_EN` defined:
  - Word access with addr[1:0]≠0, or half access with addr[1:0]=3, is legal.
  - BEAT0 covers the low bytes at the aligned word; BEAT1 covers the remaining bytes at word+4.
  - Load bytes from the two beats are merged before extension.
  - Half access with addr[1:0]=1 remains a single beat.
- Not defined: these accesses take the misaligned exception path, and the BEAT1 state is not built.

## Structure
- Add to `macros/control_rv.v`: FSM state encodings, `EXCEPTION_MISALIGNED_LOAD`, `EXCEPTION_MISALIGNED_STORE`, `EXCEPTION_BUS_ERROR`.
- Reuse the existing `MEM_ACCESS_*` constants.
- One combinational sub-module, `dmem_lane_align_rv`: byte-enable generation, store-data shift, load shift/mask/extend.

## Test plan
- LB, addr 0x1003, ack in 1 cycle, rdata 0x80_00_00_00 → BusAddr 0x1000, ByteEn 4'b1000, `owDone` at N+2, RData 0xFFFFFF80, exception SUCCESS.
- SH, addr 0x2002, wdata 0x0000BEEF, 3 wait cycles → BusWData 0xBEEF0000, ByteEn 4'b1100, `owDone` at N+5.
- LW, addr 0x3001:
  - without macro → no `owBusReq`, `owDone` at N+1, `EXCEPTION_MISALIGNED_LOAD`;
  - with macro, rdata 0x44332211 then 0x88776655 → beats at 0x3000 and 0x3004, RData 0x55443322.
- `iwAccess`=2'b11 → `EXCEPTION_ILLEGAL_INSTR`, no bus request.
- SW with no ack, TIMEOUT_CYCLES=4 → `owBusReq` high 4 cycles, then `EXCEPTION_BUS_ERROR`; repeat with ack on the 4th cycle → SUCCESS.
- `iwRst` asserted during BEAT0 wait → `owBusReq`=0 the next cycle, no `owDone`; a following LW at 0x4000 completes normally.
